// File: rtl/sparse_poly_mult_dm.sv
// Sparse x dense polynomial multiplier over GF(2) mod x^pN - 1, one rotate-and-XOR per cycle.
// Optional LFSR-scheduled dummy operations keep the cycle count fixed and data-independent.
//
//   state | meaning
//   IDLE  | waiting for load_i; latches operands and seeds the LFSR
//   RUN   | one real or dummy rotate-and-XOR per cycle, busy_o high
//   FIN   | result visible on data_o with done_o high for this single cycle
module sparse_poly_mult_dm #(
  parameter int pN     = 128,
  parameter int pW     = 8,
  parameter int pIDX_W = $clog2(pN),
  parameter int pDUMMY = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [pN-1:0]          a_i,
  input  logic [pW*pIDX_W-1:0]   pos_i,
  input  logic [15:0]            seed_i,
  input  logic                   dummy_en_i,
  output logic [pN-1:0]          data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int RC_W = $clog2(pW + 1);
  localparam int DC_W = (pDUMMY > 0) ? $clog2(pDUMMY + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                state;
  logic [pN-1:0]         a_r;
  logic [pW*pIDX_W-1:0]  pos_r;
  logic                  dummy_en_r;
  logic [15:0]           lfsr;
  logic [pN-1:0]         acc;
  (* keep = "true", dont_touch = "true" *) logic [pN-1:0] dummy_acc;
  logic [RC_W-1:0]       real_cnt;
  logic [DC_W-1:0]       dummy_cnt;

  logic [pIDX_W-1:0]     cur_pos;
  logic [pIDX_W-1:0]     shamt;
  logic                  dummy_ok;
  logic                  do_dummy;
  logic                  last_op;
  logic [pN-1:0]         rot_val;
  logic [pN-1:0]         acc_nx;
  logic [RC_W-1:0]       real_cnt_nx;
  logic [DC_W-1:0]       dummy_cnt_nx;
  logic [15:0]           lfsr_nx;

  // Up to two subtractions so a non-power-of-two pN still maps every index into range.
  function automatic logic [pIDX_W-1:0] reduce_idx(input logic [pIDX_W-1:0] x);
    int v;
    v = int'(x);
    if (v >= pN) v = v - pN;
    if (v >= pN) v = v - pN;
    return v[pIDX_W-1:0];
  endfunction

  function automatic logic [pN-1:0] rotl(input logic [pN-1:0] v, input logic [pIDX_W-1:0] s);
    logic [2*pN-1:0] dbl;
    dbl = {v, v} << s;
    return dbl[2*pN-1:pN];
  endfunction

  always_comb begin
    cur_pos = '0;
    for (int k = 0; k < pW; k++) begin
      if (real_cnt == RC_W'(k)) cur_pos = pos_r[k*pIDX_W +: pIDX_W];
    end
    dummy_ok     = dummy_en_r && (pDUMMY > 0) && (dummy_cnt != DC_W'(pDUMMY));
    do_dummy     = dummy_ok && (lfsr[0] || (real_cnt == RC_W'(pW)));
    shamt        = reduce_idx(do_dummy ? lfsr[pIDX_W-1:0] : cur_pos);
    rot_val      = rotl(a_r, shamt);
    acc_nx       = do_dummy ? acc : (acc ^ rot_val);
    real_cnt_nx  = do_dummy ? real_cnt : real_cnt + 1'b1;
    dummy_cnt_nx = do_dummy ? dummy_cnt + 1'b1 : dummy_cnt;
    last_op      = (real_cnt_nx == RC_W'(pW)) &&
                   (!dummy_en_r || (pDUMMY == 0) || (dummy_cnt_nx == DC_W'(pDUMMY)));
    lfsr_nx      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      pos_r      <= '0;
      dummy_en_r <= 1'b0;
      lfsr       <= '0;
      acc        <= '0;
      dummy_acc  <= '0;
      real_cnt   <= '0;
      dummy_cnt  <= '0;
      data_o     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (load_i) begin
            a_r        <= a_i;
            pos_r      <= pos_i;
            dummy_en_r <= dummy_en_i;
            lfsr       <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
            acc        <= '0;
            dummy_acc  <= '0;
            real_cnt   <= '0;
            dummy_cnt  <= '0;
            busy_o     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          lfsr      <= lfsr_nx;
          acc       <= acc_nx;
          real_cnt  <= real_cnt_nx;
          dummy_cnt <= dummy_cnt_nx;
          if (do_dummy) dummy_acc <= dummy_acc ^ rot_val;
          // Result and done are registered together so they appear in the FIN cycle.
          if (last_op) begin
            data_o <= acc_nx;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= FIN;
          end
        end
        FIN: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_poly_mult_dm.sv
// Directed bench for sparse_poly_mult_dm: default build plus a pDUMMY=0 build.
module tb_sparse_poly_mult_dm;
  localparam int N  = 128;
  localparam int W  = 8;
  localparam int IW = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [N-1:0]      a;
  logic [W*IW-1:0]   pos;
  logic [15:0]       seed;
  logic              den;
  logic [N-1:0]      data, data0;
  logic              busy, busy0, done, done0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sparse_poly_mult_dm #(.pN(N), .pW(W), .pDUMMY(8)) dut (
    .clk(clk), .rst(rst), .load_i(load), .a_i(a), .pos_i(pos), .seed_i(seed),
    .dummy_en_i(den), .data_o(data), .busy_o(busy), .done_o(done));

  sparse_poly_mult_dm #(.pN(N), .pW(W), .pDUMMY(0)) dut0 (
    .clk(clk), .rst(rst), .load_i(load), .a_i(a), .pos_i(pos), .seed_i(seed),
    .dummy_en_i(den), .data_o(data0), .busy_o(busy0), .done_o(done0));

  function automatic logic [W*IW-1:0] mk_pos(input int p[8]);
    logic [W*IW-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) r[k*IW +: IW] = IW'(p[k]);
    return r;
  endfunction

  // Loads one operation and watches 40 cycles; optionally pulses load_i again at sample inj.
  task automatic run_mult(input logic [N-1:0] av, input logic [W*IW-1:0] pv, input logic dv,
                          input logic [15:0] sv, input bit use0, input int inj,
                          output logic [N-1:0] res, output int busy_n, output int done_n,
                          output int done_idx, output logic [N-1:0] pre_data);
    logic b, d;
    logic [N-1:0] q;
    res = '0; busy_n = 0; done_n = 0; done_idx = -1; pre_data = '0;
    @(negedge clk);
    a = av; pos = pv; den = dv; seed = sv; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b = use0 ? busy0 : busy;
      d = use0 ? done0 : done;
      q = use0 ? data0 : data;
      if (b) busy_n++;
      if (d) begin
        done_n++;
        if (done_n == 1) begin
          done_idx = i;
          res = q;
        end
      end else if (done_n == 0) begin
        pre_data = q;
      end
      if (i == inj + 1) load = 1'b0;
      if (i == inj) begin
        a = 128'hF0; pos = mk_pos('{1, 0, 0, 0, 0, 0, 0, 0}); den = 1'b0; load = 1'b1;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; a = '0; pos = '0; seed = '0; den = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got data=%h busy=%b done=%b want 0/0/0", data, busy, done);
    end
    total++;
    if (data0 !== '0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      bad++; $display("FAIL reset_outputs_p0: got data=%h busy=%b done=%b want 0/0/0", data0, busy0, done0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] r, pre;
    int bn, dn, di;
    run_mult(128'h1, mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 16'h0, 1'b0, -10, r, bn, dn, di, pre);
    total++;
    if (r !== 128'hFF) begin bad++; $display("FAIL basic_data: got %h want ff", r); end
    total++;
    if (bn !== 8) begin bad++; $display("FAIL basic_busy: got %0d want 8", bn); end
    total++;
    if (dn !== 1 || di !== 8) begin
      bad++; $display("FAIL basic_done: got count=%0d idx=%0d want 1/8", dn, di);
    end
    total++;
    if (pre !== '0) begin bad++; $display("FAIL basic_pre_done_data: got %h want 0", pre); end
  endtask

  task automatic test_dummy_seeds();
    logic [15:0] seeds [4] = '{16'hACE1, 16'h0001, 16'hFFFF, 16'h1234};
    logic [N-1:0] r, pre;
    int bn, dn, di;
    for (int s = 0; s < 4; s++) begin
      run_mult(128'h1, mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b1, seeds[s], 1'b0, -10, r, bn, dn, di, pre);
      total++;
      if (r !== 128'hFF) begin bad++; $display("FAIL dummy_data seed=%h: got %h want ff", seeds[s], r); end
      total++;
      if (bn !== 16 || dn !== 1 || di !== 16) begin
        bad++; $display("FAIL dummy_cycles seed=%h: got busy=%0d done=%0d idx=%0d want 16/1/16",
                        seeds[s], bn, dn, di);
      end
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] r, pre, av;
    int bn, dn, di;
    av = 128'h1;
    av = av << 127;
    run_mult(av, mk_pos('{1, 2, 2, 3, 3, 4, 4, 5}), 1'b1, 16'hACE1, 1'b0, -10, r, bn, dn, di, pre);
    total++;
    if (r !== 128'h11) begin bad++; $display("FAIL wrap_data: got %h want 11", r); end
    total++;
    if (bn !== 16) begin bad++; $display("FAIL wrap_busy: got %0d want 16", bn); end
  endtask

  task automatic test_cancel();
    logic [N-1:0] r, pre;
    int bn, dn, di;
    run_mult(128'hDEADBEEF, mk_pos('{5, 5, 5, 5, 5, 5, 5, 5}), 1'b0, 16'h0, 1'b0, -10, r, bn, dn, di, pre);
    total++;
    if (r !== '0) begin bad++; $display("FAIL cancel_data: got %h want 0", r); end
    total++;
    if (pre !== 128'h11) begin bad++; $display("FAIL cancel_held_data: got %h want 11", pre); end
    total++;
    if (bn !== 8) begin bad++; $display("FAIL cancel_busy: got %0d want 8", bn); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] r, pre;
    int bn, dn, di, stray;
    run_mult(128'h1, mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 16'h0, 1'b0, -10, r, bn, dn, di, pre);
    @(negedge clk);
    a = 128'h3; pos = mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}); den = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) stray++;
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b1 || data !== 128'hFF) begin
      bad++; $display("FAIL midrst_before: got busy=%b data=%h want 1/ff", busy, data);
    end
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || data !== '0 || done !== 1'b0) begin
      bad++; $display("FAIL midrst_clear: got busy=%b data=%h done=%b want 0/0/0", busy, data, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) stray++;
      @(negedge clk);
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d stray cycles want 0", stray); end
    run_mult(128'h1, mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 16'h0, 1'b0, -10, r, bn, dn, di, pre);
    total++;
    if (r !== 128'hFF || bn !== 8) begin
      bad++; $display("FAIL midrst_reload: got data=%h busy=%0d want ff/8", r, bn);
    end
  endtask

  task automatic test_protocol();
    logic [N-1:0] r, pre;
    int bn, dn, di;
    run_mult(128'h1, mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b1, 16'h0000, 1'b0, -10, r, bn, dn, di, pre);
    total++;
    if (r !== 128'hFF || bn !== 16) begin
      bad++; $display("FAIL seed_zero: got data=%h busy=%0d want ff/16", r, bn);
    end
    run_mult(128'h1, mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 16'h0, 1'b0, 2, r, bn, dn, di, pre);
    total++;
    if (r !== 128'hFF || bn !== 8 || dn !== 1) begin
      bad++; $display("FAIL load_in_run: got data=%h busy=%0d done=%0d want ff/8/1", r, bn, dn);
    end
    run_mult(128'h1, mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 16'h0, 1'b0, 8, r, bn, dn, di, pre);
    total++;
    if (r !== 128'hFF || bn !== 8 || dn !== 1) begin
      bad++; $display("FAIL load_in_fin: got data=%h busy=%0d done=%0d want ff/8/1", r, bn, dn);
    end
  endtask

  task automatic test_pdummy0();
    logic [N-1:0] r, pre;
    int bn, dn, di;
    run_mult(128'h1, mk_pos('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b1, 16'hACE1, 1'b1, -10, r, bn, dn, di, pre);
    total++;
    if (r !== 128'hFF) begin bad++; $display("FAIL pdummy0_data: got %h want ff", r); end
    total++;
    if (bn !== 8 || dn !== 1 || di !== 8) begin
      bad++; $display("FAIL pdummy0_cycles: got busy=%0d done=%0d idx=%0d want 8/1/8", bn, dn, di);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dummy_seeds();
    test_wrap();
    test_cancel();
    test_reset_mid();
    test_protocol();
    test_pdummy0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
